// File: rtl/md_sequencer.sv
// HI/LO owner for the E-stage multiply/divide unit: latches the 64-bit result at start,
// models mult/div latency with a down-counter and commits HI/LO when the count expires.
module md_sequencer #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        D_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] out
);

  // state | meaning
  // IDLE  | no mult/div in flight; mthi/mtlo accepted, start_e launches an op
  // RUN   | result pending; cnt_q holds remaining busy cycles
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] pend_q, pend_d;
  logic        ok_q, ok_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        start_e;
  logic [63:0] prod_s, prod_u, result;
  logic [31:0] a_mag, b_mag, dvd, dvs, uq, ur, quo, rem;

  assign start_e = (op <= 4'd3);

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  // One unsigned divider serves both div flavours; signed div works on magnitudes.
  // A zero divisor is replaced by 1 to keep the divider defined; that result is never committed.
  assign a_mag = A[31] ? (32'd0 - A) : A;
  assign b_mag = B[31] ? (32'd0 - B) : B;
  assign dvd   = op[0] ? A : a_mag;
  assign dvs   = (B == 32'd0) ? 32'd1 : (op[0] ? B : b_mag);
  assign uq    = dvd / dvs;
  assign ur    = dvd % dvs;
  assign quo   = (!op[0] && (A[31] ^ B[31])) ? (32'd0 - uq) : uq;
  assign rem   = (!op[0] && A[31]) ? (32'd0 - ur) : ur;

  always_comb begin
    result = 64'd0;
    case (op)
      4'd0:        result = prod_s;
      4'd1:        result = prod_u;
      4'd2, 4'd3:  result = {rem, quo};
      default:     result = 64'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ok_d    = ok_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start_e) begin
          pend_d  = result;
          ok_d    = !(op[1] && (B == 32'd0));
          cnt_d   = op[1] ? DIV_CNT : MULT_CNT;
          state_d = RUN;
        end else if (op == 4'd6) begin
          hi_d = A;
        end else if (op == 4'd7) begin
          lo_d = A;
        end
      end
      RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          if (ok_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      pend_q  <= 64'd0;
      ok_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ok_q    <= ok_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign stall = D_md & (start_e | busy);
  assign HI    = hi_q;
  assign LO    = lo_q;

  always_comb begin
    out = 32'd0;
    if (op == 4'd4)      out = hi_q;
    else if (op == 4'd5) out = lo_q;
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: two instances (default latencies and MULT_LAT=1/DIV_LAT=15)
// share stimulus; a cycle-level reference model queues expected outputs for a separate monitor.
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op;
  logic [31:0] A, B;
  logic        D_md;
  logic [1:0]  busy_w, stall_w;
  logic [31:0] hi_w [2];
  logic [31:0] lo_w [2];
  logic [31:0] out_w [2];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  md_sequencer #(.MULT_LAT(5), .DIV_LAT(10)) u_dut (
    .clk(clk), .reset(reset), .op(op), .A(A), .B(B), .D_md(D_md),
    .busy(busy_w[0]), .stall(stall_w[0]), .HI(hi_w[0]), .LO(lo_w[0]), .out(out_w[0])
  );

  md_sequencer #(.MULT_LAT(1), .DIV_LAT(15)) u_fast (
    .clk(clk), .reset(reset), .op(op), .A(A), .B(B), .D_md(D_md),
    .busy(busy_w[1]), .stall(stall_w[1]), .HI(hi_w[1]), .LO(lo_w[1]), .out(out_w[1])
  );

  typedef struct packed {
    logic [1:0]       busy;
    logic [1:0]       stall;
    logic [1:0][31:0] out;
    logic [1:0][31:0] hi;
    logic [1:0][31:0] lo;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state per instance
  int          lat_m [2] = '{5, 1};
  int          lat_d [2] = '{10, 15};
  int          m_left [2];
  logic [31:0] m_hi [2];
  logic [31:0] m_lo [2];
  logic [63:0] m_pend [2];
  bit          m_ok [2];

  function automatic logic [63:0] md_ref(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    md_ref = 64'd0;
    case (o)
      4'd0: begin q = sa * sb; md_ref = q; end
      4'd1: md_ref = ua * ub;
      4'd2: if (b != 0) begin q = sa / sb; r = sa % sb; md_ref = {r[31:0], q[31:0]}; end
      4'd3: if (b != 0) md_ref = {a % b, a / b};
      default: md_ref = 64'd0;
    endcase
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      m_left[d] = 0; m_hi[d] = 0; m_lo[d] = 0; m_pend[d] = 0; m_ok[d] = 0;
    end
  endtask

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", nm, d, $time, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      for (int d = 0; d < 2; d++) begin
        chk("busy",  d, {31'd0, busy_w[d]},  {31'd0, e.busy[d]});
        chk("stall", d, {31'd0, stall_w[d]}, {31'd0, e.stall[d]});
        chk("out",   d, out_w[d], e.out[d]);
        chk("HI",    d, hi_w[d],  e.hi[d]);
        chk("LO",    d, lo_w[d],  e.lo[d]);
      end
    end
  end

  // Called just after a rising edge: drive one cycle of stimulus, queue expectation, advance model.
  task automatic step(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic dmd);
    exp_t e;
    op = o; A = a; B = b; D_md = dmd;
    for (int d = 0; d < 2; d++) begin
      e.busy[d]  = (m_left[d] > 0);
      e.stall[d] = dmd && (o <= 4'd3 || m_left[d] > 0);
      e.out[d]   = (o == 4'd4) ? m_hi[d] : (o == 4'd5) ? m_lo[d] : 32'd0;
      e.hi[d]    = m_hi[d];
      e.lo[d]    = m_lo[d];
    end
    exp_q.push_back(e);
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (m_left[d] > 0) begin
        m_left[d]--;
        if (m_left[d] == 0 && m_ok[d]) begin
          m_hi[d] = m_pend[d][63:32];
          m_lo[d] = m_pend[d][31:0];
        end
      end else if (o <= 4'd3) begin
        m_pend[d] = md_ref(o, a, b);
        m_ok[d]   = !(o >= 4'd2 && b == 32'd0);
        m_left[d] = (o >= 4'd2) ? lat_d[d] : lat_m[d];
      end else if (o == 4'd6) begin
        m_hi[d] = a;
      end else if (o == 4'd7) begin
        m_lo[d] = a;
      end
    end
    #1;
  endtask

  task automatic idle(input int n, input logic dmd);
    repeat (n) step(4'hF, 32'd0, 32'd0, dmd);
  endtask

  // Reset asserted between edges so the negedge sample proves it acts without a clock.
  task automatic do_reset();
    exp_t e;
    op = 4'hF; A = 0; B = 0; D_md = 0;
    reset = 1'b0;
    e = '0;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
    reset = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0]  o;
    logic [31:0] a, b;
    int          r;
    op = 4'hF; A = 0; B = 0; D_md = 0; reset = 1'b0;
    model_clear();
    #1;
    do_reset();

    step(4'd0, 32'hFFFF_FFFF, 32'd2, 1'b0); idle(16, 1'b0);
    step(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0); idle(16, 1'b0);
    step(4'd2, 32'hFFFF_FFF9, 32'd2, 1'b0); idle(16, 1'b0);
    step(4'd3, 32'd7, 32'd2, 1'b0);         idle(16, 1'b0);

    step(4'd6, 32'h1234, 32'd0, 1'b0);
    step(4'd7, 32'h5678, 32'd0, 1'b0);
    step(4'd2, 32'd99, 32'd0, 1'b0);        idle(16, 1'b0);
    step(4'd4, 32'd0, 32'd0, 1'b0);
    step(4'd5, 32'd0, 32'd0, 1'b0);

    step(4'd0, 32'd6, 32'd7, 1'b1);
    idle(2, 1'b1);
    step(4'd1, 32'd3, 32'd3, 1'b1);
    idle(14, 1'b1);
    idle(2, 1'b0);

    step(4'd2, 32'd100, 32'd7, 1'b0);
    idle(3, 1'b0);
    do_reset();
    step(4'd0, 32'd3, 32'd4, 1'b0);         idle(16, 1'b0);

    step(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); idle(16, 1'b0);
    step(4'd4, 32'd0, 32'd0, 1'b0);
    step(4'd5, 32'd0, 32'd0, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 11);
      o = (r > 7) ? 4'hF : 4'(r);
      case ($urandom_range(0, 5))
        0:       a = 32'h8000_0000;
        1:       a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 9);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 199) == 0) do_reset();
      else step(o, a, b, 1'($urandom_range(0, 1)));
    end

    idle(20, 1'b0);
    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
